// File: rtl/acl_timer_pkg.sv
// Shared FSM encoding, status word layout and sizing helper for the timer sampler.
package acl_timer_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_CLR    = 3'd1;
  localparam logic [ST_W-1:0] ST_RUN    = 3'd2;
  localparam logic [ST_W-1:0] ST_RDREQ  = 3'd3;
  localparam logic [ST_W-1:0] ST_RDWAIT = 3'd4;

  // Status word: {count, ovf, evt_drop} starting at bit 0
  localparam int unsigned STAT_EVT_DROP = 0;
  localparam int unsigned STAT_OVF      = 1;
  localparam int unsigned STAT_CNT_LSB  = 2;

  // Occupancy counter must represent 0..depth inclusive
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/acl_sample_fifo.sv
// DEPTH x WIDTH sample FIFO; a push into a full FIFO only lands when a pop frees a slot that cycle.
module acl_sample_fifo
  import acl_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head_c,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full_c,
  output logic                     o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  assign w_do_pop  = i_pop & ~o_empty_c;
  assign w_do_push = i_push & (~o_full_c | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/acl_timer_sampler.sv
// Measures start/stop intervals by clearing and reading an Avalon-MM timer, queuing samples for a host.
module acl_timer_sampler
  import acl_timer_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int          SEL_2X = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_event,
  input  logic                 stop_event,
  output logic [1:0]           tmr_address,
  output logic                 tmr_read,
  output logic                 tmr_write,
  output logic [WIDTH-1:0]     tmr_writedata,
  output logic [WIDTH/8-1:0]   tmr_byteenable,
  input  logic                 tmr_waitrequest,
  input  logic [WIDTH-1:0]     tmr_readdata,
  input  logic                 tmr_readdatavalid,
  input  logic                 host_address,
  input  logic                 host_read,
  input  logic                 host_write,
  input  logic [WIDTH-1:0]     host_writedata,
  output logic [WIDTH-1:0]     host_readdata,
  output logic                 host_readdatavalid,
  output logic                 host_waitrequest
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_state_nxt;
  logic             r_tmr_read;
  logic             r_tmr_write;
  logic             w_tmr_read_nxt;
  logic             w_tmr_write_nxt;
  logic             w_push;
  logic             w_drop_set;
  logic             r_ovf;
  logic             r_evt_drop;
  logic [WIDTH-1:0] r_host_rdata;
  logic             r_host_rvalid;
  logic [WIDTH-1:0] w_head;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_ovf_set;
  logic [WIDTH-1:0] w_status;
  logic             w_unused_wdata;

  assign tmr_address        = 2'b00;
  assign tmr_writedata      = (SEL_2X != 0) ? WIDTH'(1) : '0;
  assign tmr_byteenable     = '1;
  assign tmr_read           = r_tmr_read;
  assign tmr_write          = r_tmr_write;
  assign host_readdata      = r_host_rdata;
  assign host_readdatavalid = r_host_rvalid;
  assign host_waitrequest   = 1'b0;
  assign w_unused_wdata     = ^host_writedata[WIDTH-1:2];

  // Next state; strobes follow the next state so each is high exactly while in its state
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_drop_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_event) w_state_nxt = ST_CLR;
      end
      ST_CLR: begin
        w_drop_set = start_event | stop_event;
        if (!tmr_waitrequest) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop_event)       w_state_nxt = ST_RDREQ;
        else if (start_event) w_state_nxt = ST_CLR;
      end
      ST_RDREQ: begin
        w_drop_set = start_event | stop_event;
        if (!tmr_waitrequest) w_state_nxt = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        w_drop_set = start_event | stop_event;
        if (tmr_readdatavalid) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_tmr_write_nxt = (w_state_nxt == ST_CLR);
    w_tmr_read_nxt  = (w_state_nxt == ST_RDREQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tmr_write <= 1'b0;
      r_tmr_read  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmr_write <= w_tmr_write_nxt;
      r_tmr_read  <= w_tmr_read_nxt;
    end
  end

  assign w_pop     = host_read & ~host_address & ~w_empty;
  assign w_ovf_set = w_push & w_full & ~w_pop;

  acl_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (tmr_readdata),
    .o_head_c  (w_head),
    .o_count   (w_count),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  always_comb begin
    w_status                           = '0;
    w_status[STAT_EVT_DROP]            = r_evt_drop;
    w_status[STAT_OVF]                 = r_ovf;
    w_status[STAT_CNT_LSB +: CW]       = w_count;
  end

  // Sticky flags: a new event in the same cycle as a host clear keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf      <= 1'b0;
      r_evt_drop <= 1'b0;
    end else begin
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (host_write && host_address && host_writedata[STAT_OVF])
        r_ovf <= 1'b0;
      if (w_drop_set)
        r_evt_drop <= 1'b1;
      else if (host_write && host_address && host_writedata[STAT_EVT_DROP])
        r_evt_drop <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_host_rvalid <= host_read;
      if (host_read) r_host_rdata <= host_address ? w_status : (w_empty ? '0 : w_head);
    end
  end

endmodule
